switch_arbiter: RTL and testbench
=================================

SWITCH_ARBITER -- requirements
Module: switch_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: FIFO word width.
REQ-002 The block SHALL have parameter LEN_W, default 3: width of the header payload-length field at bits [LEN_W+1:2].
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have ports data1, data2, data3  input  DATA_W  head word of the show-ahead input FIFO 1/2/3.
REQ-006 The block SHALL have ports empty1, empty2, empty3  input  1  input FIFO 1/2/3 empty flag.
REQ-007 The block SHALL have ports sel1, sel2, sel3  output  2  output-port mux select: 0 = idle, 1..3 = source input index.
REQ-008 The block SHALL have ports rdreq1, rdreq2, rdreq3  output  1  pop strobe to input FIFO 1/2/3.
REQ-009 The block SHALL have ports valid1, valid2, valid3  output  1  output port 1/2/3 carries a valid beat this cycle.

Function
REQ-010 Packet format SHALL be a header word (bits[1:0] = destination port 1..3, 0 = discard; bits[LEN_W+1:2] = payload beats N) followed by N payload words; total beats = 1+N, range 1..2^LEN_W.
REQ-011 Each input SHALL run its own FSM with states IDLE, XFER and DROP.
REQ-012 IDLE, FIFO non-empty, dest 0: the input SHALL go to DROP and pop all 1+N beats without granting any output.
REQ-013 IDLE, FIFO non-empty, dest j: the input SHALL request output j.
REQ-014 Each output j SHALL keep a registered lock flag and a round-robin pointer.
REQ-015 When output j is unlocked, arbitration SHALL grant among requesters in priority order starting at pointer+1 (wrapping 3->1).
REQ-016 A grant SHALL register sel_j = i, set the lock, and move input i to XFER at the same edge.
REQ-017 Grant latency SHALL be one cycle: a header visible at cycle 0 gives sel_j = i and rdreq_i = 1 in cycle 1.
REQ-018 rdreq_i SHALL be combinational: (state XFER or DROP) AND NOT empty_i.
REQ-019 valid_j SHALL equal rdreq of the input currently selected on output j; the header is forwarded as the first beat.
REQ-020 A per-input beat counter SHALL load 1+N at entry to XFER/DROP and decrement on each pop.
REQ-021 If the FIFO empties mid-packet, the input SHALL stall with no pop and the lock held, then resume without loss.
REQ-022 At the edge popping the last beat: the input SHALL return to IDLE, the lock SHALL clear, sel_j SHALL become 0 and pointer_j SHALL be set to i.
REQ-023 A newly released output SHALL NOT be granted in the same edge; the earliest regrant is the following edge (one idle cycle).
REQ-024 Three different outputs MAY be granted in the same edge; each input SHALL hold at most one grant.
REQ-025 rdreq SHALL never be asserted to an empty FIFO.

Reset
REQ-026 While rst_n is low: all FSMs IDLE, counters 0, locks clear, sel* = 0, rdreq* = 0, valid* = 0, all pointers = 3 (input 1 highest priority).
REQ-027 Reset asserted mid-packet SHALL abort the packet immediately; no recovery of partial packets.

Structure
REQ-028 Package switch_pkg SHALL hold: port-index typedef (2 bits), input FSM state enum, header field position constants, IDLE_SEL = 0.
REQ-029 A sub-module rr_arb3 SHALL be instantiated once per output: 3 request bits, 2-bit pointer in, one-hot grant out, purely combinational.

Verification
REQ-030 Single packet: input 1 header 8'h09 (dest 1, N=2), FIFO non-empty -> cycle 1..3 sel1 = 1, rdreq1 = valid1 = 1; cycle 4 sel1 = 0.
REQ-031 Contention: inputs 1, 2, 3 all send dest 2, N=0, after reset -> grants in order 1, 2, 3, each followed by one idle cycle on output 2.
REQ-032 Fairness: input 1 re-requests dest 3 continuously while input 3 also requests dest 3 -> grants alternate 1, 3, 1, 3.
REQ-033 Stall: empty2 goes high for 3 cycles after the header pop of an N=3 packet -> no rdreq2 during the stall, lock held, 4 beats total.
REQ-034 Parallel and discard: input 1 -> dest 3, input 2 -> dest 1, input 3 header dest 0 with N=1 -> both outputs granted in the same cycle; input 3 pops 2 beats with valid* never driven by it.
REQ-035 Reset mid-packet: rst_n low during beat 2 of 4 -> all outputs 0 asynchronously; after release, input 1 wins the first contention.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and constants for the 3x3 packet switch arbiter.
// Port indices, input FSM states, header field positions, helpers.
package switch_pkg;

  typedef logic [1:0] port_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } in_state_t;

  localparam int    DEST_LSB = 0;
  localparam int    DEST_MSB = 1;
  localparam int    LEN_LSB  = 2;
  localparam port_t IDLE_SEL = 2'd0;
  localparam port_t PTR_RST  = 2'd3;

  // One-hot grant to 1-based port index.
  function automatic port_t oh2idx(
    input logic [2:0] oh
  );
    port_t idx;
    idx = IDLE_SEL;
    if (oh[0])      idx = 2'd1;
    else if (oh[1]) idx = 2'd2;
    else if (oh[2]) idx = 2'd3;
    return idx;
  endfunction

  // Pick the bit of v owned by 1-based index s; 0 when idle.
  function automatic logic pick(
    input port_t      s,
    input logic [2:0] v
  );
    logic b;
    b = 1'b0;
    case (s)
      2'd1:    b = v[0];
      2'd2:    b = v[1];
      2'd3:    b = v[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/switch_arbiter_rr_arb3.sv
// Combinational 3-way round-robin arbiter.
// Ports: i_req (bit0 = input 1), i_ptr (last winner), o_gnt one-hot.
module rr_arb3
  import switch_pkg::*;
(
  input  logic [2:0] i_req,
  input  port_t      i_ptr,
  output logic [2:0] o_gnt
);

  // Priority starts just after the last winner, wrapping 3->1.
  always_comb begin
    o_gnt = 3'b000;
    case (i_ptr)
      2'd1: begin
        if (i_req[1])      o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
      end
      2'd2: begin
        if (i_req[2])      o_gnt = 3'b100;
        else if (i_req[0]) o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
      end
      default: begin
        if (i_req[0])      o_gnt = 3'b001;
        else if (i_req[1]) o_gnt = 3'b010;
        else if (i_req[2]) o_gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/switch_arbiter.sv
// 3x3 packet switch arbiter: per-input IDLE/XFER/DROP FSMs feeding
// per-output lock + round-robin grant. Ports: dataN/emptyN from
// show-ahead FIFOs, rdreqN pops, selN/validN drive output muxes.
module switch_arbiter
  import switch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  output logic [1:0]        sel1,
  output logic [1:0]        sel2,
  output logic [1:0]        sel3,
  output logic              rdreq1,
  output logic              rdreq2,
  output logic              rdreq3,
  output logic              valid1,
  output logic              valid2,
  output logic              valid3
);

  localparam int CNT_W = LEN_W + 1;

  logic [DATA_W-1:0] w_data [3];
  logic [2:0]        w_empty;
  port_t             w_dest [3];
  logic [CNT_W-1:0]  w_beats [3];
  logic [2:0]        w_hdr;
  logic [2:0]        w_drop;
  logic [2:0]        w_rdreq;
  logic [2:0]        w_last;
  logic [2:0]        w_won;
  logic [2:0]        w_req [3];
  logic [2:0]        w_gnt [3];
  logic [2:0]        w_rel;
  logic [2:0]        w_valid;
  logic              w_unused;

  in_state_t         r_state [3];
  logic [CNT_W-1:0]  r_cnt [3];
  logic [2:0]        r_lock;
  port_t             r_sel [3];
  port_t             r_ptr [3];

  assign w_data[0] = data1;
  assign w_data[1] = data2;
  assign w_data[2] = data3;
  assign w_empty   = {empty3, empty2, empty1};
  assign w_unused  = ^{w_data[0], w_data[1], w_data[2]};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_dest[i]  = w_data[i][DEST_MSB:DEST_LSB];
      w_beats[i] = CNT_W'(w_data[i][LEN_LSB+LEN_W-1:LEN_LSB])
                 + CNT_W'(1);
      w_hdr[i]   = (r_state[i] == ST_IDLE) && !w_empty[i];
      w_drop[i]  = w_hdr[i] && (w_dest[i] == IDLE_SEL);
      w_rdreq[i] = ((r_state[i] == ST_XFER) ||
                    (r_state[i] == ST_DROP)) && !w_empty[i];
      w_last[i]  = w_rdreq[i] && (r_cnt[i] == CNT_W'(1));
    end
  end

  // Locked outputs present no requests, so a release and a
  // regrant never share an edge.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      w_req[j] = 3'b000;
      for (int i = 0; i < 3; i++) begin
        w_req[j][i] = !r_lock[j] && w_hdr[i] &&
                      (w_dest[i] == port_t'(j + 1));
      end
    end
  end

  for (genvar j = 0; j < 3; j++) begin : g_arb
    rr_arb3 u_arb (
      .i_req (w_req[j]),
      .i_ptr (r_ptr[j]),
      .o_gnt (w_gnt[j])
    );
  end

  always_comb begin
    w_won = w_gnt[0] | w_gnt[1] | w_gnt[2];
    for (int j = 0; j < 3; j++) begin
      w_rel[j]   = r_lock[j] && pick(r_sel[j], w_last);
      w_valid[j] = pick(r_sel[j], w_rdreq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_won[i]) begin
              r_state[i] <= ST_XFER;
              r_cnt[i]   <= w_beats[i];
            end else if (w_drop[i]) begin
              r_state[i] <= ST_DROP;
              r_cnt[i]   <= w_beats[i];
            end
          end
          ST_XFER, ST_DROP: begin
            if (w_rdreq[i]) begin
              r_cnt[i] <= r_cnt[i] - CNT_W'(1);
              if (w_last[i]) r_state[i] <= ST_IDLE;
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) begin
        r_lock[j] <= 1'b0;
        r_sel[j]  <= IDLE_SEL;
        r_ptr[j]  <= PTR_RST;
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (w_rel[j]) begin
          r_lock[j] <= 1'b0;
          r_sel[j]  <= IDLE_SEL;
          r_ptr[j]  <= r_sel[j];
        end else if (|w_gnt[j]) begin
          r_lock[j] <= 1'b1;
          r_sel[j]  <= oh2idx(w_gnt[j]);
        end
      end
    end
  end

  assign sel1   = r_sel[0];
  assign sel2   = r_sel[1];
  assign sel3   = r_sel[2];
  assign rdreq1 = w_rdreq[0];
  assign rdreq2 = w_rdreq[1];
  assign rdreq3 = w_rdreq[2];
  assign valid1 = w_valid[0];
  assign valid2 = w_valid[1];
  assign valid3 = w_valid[2];

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed bench for switch_arbiter with queue-modelled input FIFOs.
// Steps one clock at a time and checks outputs #2 after each edge.
module tb_switch_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] data1, data2, data3;
  logic       empty1, empty2, empty3;
  logic [1:0] sel1, sel2, sel3;
  logic       rdreq1, rdreq2, rdreq3;
  logic       valid1, valid2, valid3;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];
  logic [2:0] stall;
  int         pops [3];
  int         n_cmp;
  int         n_bad;

  logic [5:0] e2 [6];
  logic [2:0] e3 [8];

  switch_arbiter #(.DATA_W(8), .LEN_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data1  (data1),
    .data2  (data2),
    .data3  (data3),
    .empty1 (empty1),
    .empty2 (empty2),
    .empty3 (empty3),
    .sel1   (sel1),
    .sel2   (sel2),
    .sel3   (sel3),
    .rdreq1 (rdreq1),
    .rdreq2 (rdreq2),
    .rdreq3 (rdreq3),
    .valid1 (valid1),
    .valid2 (valid2),
    .valid3 (valid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp_v
  );
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic refresh();
    empty1 = stall[0] || (q1.size() == 0);
    empty2 = stall[1] || (q2.size() == 0);
    empty3 = stall[2] || (q3.size() == 0);
    data1  = (q1.size() != 0) ? q1[0] : 8'h00;
    data2  = (q2.size() != 0) ? q2[0] : 8'h00;
    data3  = (q3.size() != 0) ? q3[0] : 8'h00;
  endtask

  task automatic step();
    logic [2:0] rq;
    logic [2:0] em;
    rq = {rdreq3, rdreq2, rdreq1};
    em = {empty3, empty2, empty1};
    chk("no_empty_pop", {5'd0, rq & em}, 8'h00);
    @(posedge clk);
    #1;
    if (rq[0] && q1.size() != 0) begin
      void'(q1.pop_front()); pops[0]++;
    end
    if (rq[1] && q2.size() != 0) begin
      void'(q2.pop_front()); pops[1]++;
    end
    if (rq[2] && q3.size() != 0) begin
      void'(q3.pop_front()); pops[2]++;
    end
    refresh();
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"}, {2'd0, sel1, sel2, sel3}, 8'h00);
    chk({tag, "_rd"}, {5'd0, rdreq1, rdreq2, rdreq3}, 8'h00);
    chk({tag, "_vld"}, {5'd0, valid1, valid2, valid3}, 8'h00);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    stall = 3'b000;
    pops  = '{0, 0, 0};
    rst_n = 1'b0;
    refresh();
    #2;
    chk_idle("rst_t0");
    step();
    step();
    chk_idle("rst_hold");
    rst_n = 1'b1;

    // Single packet dest 1, N=2
    q1.push_back(8'h09);
    q1.push_back(8'hA1);
    q1.push_back(8'hA2);
    refresh();
    #1;
    step();
    chk("t1_c1", {4'd0, sel1, rdreq1, valid1}, 8'h07);
    chk("t1_c1_oth", {4'd0, sel2, sel3}, 8'h00);
    step();
    chk("t1_c2", {4'd0, sel1, rdreq1, valid1}, 8'h07);
    step();
    chk("t1_c3", {4'd0, sel1, rdreq1, valid1}, 8'h07);
    step();
    chk("t1_c4", {4'd0, sel1, rdreq1, valid1}, 8'h00);

    // Contention on output 2 after reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    q1.push_back(8'h02);
    q2.push_back(8'h02);
    q3.push_back(8'h02);
    refresh();
    #1;
    e2 = '{6'b01_1_100, 6'b0, 6'b10_1_010,
           6'b0, 6'b11_1_001, 6'b0};
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("t2_c%0d", c + 1),
          {2'd0, sel2, valid2, rdreq1, rdreq2, rdreq3},
          {2'd0, e2[c]});
    end

    // Fairness on output 3 between inputs 1 and 3
    q1.push_back(8'h03);
    q1.push_back(8'h03);
    q3.push_back(8'h03);
    q3.push_back(8'h03);
    refresh();
    #1;
    e3 = '{3'b011, 3'b000, 3'b111, 3'b000,
           3'b011, 3'b000, 3'b111, 3'b000};
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("t3_c%0d", c + 1),
          {5'd0, sel3, valid3}, {5'd0, e3[c]});
    end

    // Stall mid-packet: input 2 -> dest 1, N=3
    pops = '{0, 0, 0};
    q2.push_back(8'h0D);
    q2.push_back(8'hB1);
    q2.push_back(8'hB2);
    q2.push_back(8'hB3);
    refresh();
    #1;
    step();
    chk("t4_hdr", {4'd0, sel1, rdreq2, valid1}, 8'h0B);
    stall[1] = 1'b1;
    step();
    chk("t4_st1", {4'd0, sel1, rdreq2, valid1}, 8'h08);
    step();
    chk("t4_st2", {4'd0, sel1, rdreq2, valid1}, 8'h08);
    step();
    chk("t4_st3", {4'd0, sel1, rdreq2, valid1}, 8'h08);
    stall[1] = 1'b0;
    step();
    chk("t4_b1", {4'd0, sel1, rdreq2, valid1}, 8'h0B);
    step();
    chk("t4_b2", {4'd0, sel1, rdreq2, valid1}, 8'h0B);
    step();
    chk("t4_b3", {4'd0, sel1, rdreq2, valid1}, 8'h0B);
    step();
    chk("t4_end", {4'd0, sel1, rdreq2, valid1}, 8'h00);
    chk("t4_pops", 8'(pops[1]), 8'd4);

    // Parallel grants plus discard on input 3
    pops = '{0, 0, 0};
    q1.push_back(8'h07);
    q1.push_back(8'hC1);
    q2.push_back(8'h01);
    q3.push_back(8'h04);
    q3.push_back(8'hEE);
    refresh();
    #1;
    step();
    chk("t5_c1_sel", {2'd0, sel1, sel2, sel3}, 8'h21);
    chk("t5_c1_rd", {5'd0, rdreq1, rdreq2, rdreq3}, 8'h07);
    chk("t5_c1_vld", {5'd0, valid1, valid2, valid3}, 8'h05);
    step();
    chk("t5_c2_sel", {2'd0, sel1, sel2, sel3}, 8'h01);
    chk("t5_c2_rd", {5'd0, rdreq1, rdreq2, rdreq3}, 8'h05);
    chk("t5_c2_vld", {5'd0, valid1, valid2, valid3}, 8'h01);
    step();
    chk_idle("t5_c3");
    chk("t5_pops3", 8'(pops[2]), 8'd2);

    // Leave output 2 pointer at 2 so reset must restore it
    q2.push_back(8'h02);
    refresh();
    #1;
    step();
    chk("wu_c1", {6'd0, sel2}, 8'h02);
    step();
    chk("wu_c2", {6'd0, sel2}, 8'h00);

    // Reset during beat 2 of 4
    q1.push_back(8'h0E);
    q1.push_back(8'hD1);
    q1.push_back(8'hD2);
    q1.push_back(8'hD3);
    refresh();
    #1;
    step();
    chk("t6_b1", {5'd0, sel2, valid2}, 8'h03);
    step();
    chk("t6_b2", {5'd0, sel2, valid2}, 8'h03);
    rst_n = 1'b0;
    #1;
    chk_idle("t6_async");
    q1.delete();
    q2.delete();
    q3.delete();
    refresh();
    step();
    rst_n = 1'b1;
    q1.push_back(8'h02);
    q2.push_back(8'h02);
    q3.push_back(8'h02);
    refresh();
    #1;
    step();
    chk("t6_first",
        {3'd0, sel2, rdreq1, rdreq2, rdreq3}, 8'h0C);
    step();
    step();
    chk("t6_second", {6'd0, sel2}, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
